// File: rtl/rv_iopmp_pkg.sv
// -----------------------------------------------------------------------------
// rv_iopmp_pkg
// Shared types and constants for the IOPMP check scheduler and its error latch.
//   access_t      : access type presented to the decision logic, one-hot {x,w,r}
//   ERR_*         : error type codes reported in the error record
//   sched_state_e : scheduler FSM states
//   err_record_t  : first-error record handed to the CSR block
//   deny_type()   : error type reported for a denied check
// -----------------------------------------------------------------------------
package rv_iopmp_pkg;

   // Widths of the error record fields; the scheduler resizes into these.
   localparam int unsigned REC_ADDR_W  = 64;
   localparam int unsigned REC_SID_W   = 8;
   localparam int unsigned ERR_ENTRY_W = 16;

   typedef enum logic [2:0] {
      ACC_NONE  = 3'b000,
      ACC_READ  = 3'b001,
      ACC_WRITE = 3'b010,
      ACC_EXEC  = 3'b100
   } access_t;

   localparam logic [2:0] ERR_READ   = 3'h1;
   localparam logic [2:0] ERR_WRITE  = 3'h2;
   localparam logic [2:0] ERR_EXEC   = 3'h3;
   localparam logic [2:0] ERR_NOHIT  = 3'h5;
   localparam logic [2:0] ERR_UNKSID = 3'h6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      RESP  = 2'd2
   } sched_state_e;

   typedef struct packed {
      logic [2:0]             etype;
      logic [ERR_ENTRY_W-1:0] entry;
      logic [REC_SID_W-1:0]   sid;
      logic [REC_ADDR_W-1:0]  addr;
      access_t                ttype;
   } err_record_t;

   // A deny without an explicit error from the decision logic means no entry
   // matched at all, which is reported as a no-hit error.
   function automatic logic [2:0] deny_type(input logic dl_err, input logic [2:0] dl_type);
      return dl_err ? dl_type : ERR_NOHIT;
   endfunction

endpackage

// File: rtl/rv_iopmp_err_capture.sv
// -----------------------------------------------------------------------------
// rv_iopmp_err_capture
// First-error latch. Holds the first captured error record until software
// clears it; errors arriving while a record is held are dropped.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   capture_i      : a denied check completes this cycle
//   clear_i        : write-1-clear of the held record
//   rec_i          : record describing the denied check
//   valid_o        : a record is held (interrupt source)
//   rec_o          : held record
// -----------------------------------------------------------------------------
module rv_iopmp_err_capture
   import rv_iopmp_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        capture_i,
   input  logic        clear_i,
   input  err_record_t rec_i,
   output logic        valid_o,
   output err_record_t rec_o
);

   logic        valid_q, valid_d;
   err_record_t rec_q, rec_d;

   // A clear in the same cycle as a new error frees the slot for that error,
   // so the new error is kept rather than lost.
   always_comb begin
      valid_d = valid_q;
      rec_d   = rec_q;
      if (capture_i && (!valid_q || clear_i)) begin
         valid_d = 1'b1;
         rec_d   = rec_i;
      end else if (clear_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         rec_q   <= '0;
      end else begin
         valid_q <= valid_d;
         rec_q   <= rec_d;
      end
   end

   assign valid_o = valid_q;
   assign rec_o   = rec_q;

endmodule

// File: rtl/rv_iopmp_chk_sched.sv
// -----------------------------------------------------------------------------
// rv_iopmp_chk_sched
// Shares one IOPMP match/decision path between the AXI AR and AW request
// ports. Requests are granted round-robin, registered, presented to the
// decision logic for one cycle, and answered with a per-port allow/deny
// response. The first denied request is latched as an error record.
// Ports:
//   clk_i, rst_ni                 : clock, asynchronous active-low reset
//   enable_i                      : IOPMP global enable, sampled at grant
//   rd_req_* / rd_addr/len/sid_i  : AR request handshake and fields
//   rd_exec_i                     : AR is an instruction fetch
//   wr_req_* / wr_addr/len/sid_i  : AW request handshake and fields
//   rsp_valid/port/allow_o        : decision response, held until rsp_ready_i
//   chk_addr/len/sid/access_o     : request presented to the decision logic
//   dl_allow/err/err_type/err_entry_i : decision logic result
//   err_clear_i                   : write-1-clear of the error record
//   err_valid_o, err_*_o          : latched first-error record
// -----------------------------------------------------------------------------
module rv_iopmp_chk_sched
   import rv_iopmp_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned LEN_WIDTH  = 8,
   parameter int unsigned SID_WIDTH  = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  enable_i,

   input  logic                  rd_req_valid_i,
   output logic                  rd_req_ready_o,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   input  logic [LEN_WIDTH-1:0]  rd_len_i,
   input  logic [SID_WIDTH-1:0]  rd_sid_i,
   input  logic                  rd_exec_i,

   input  logic                  wr_req_valid_i,
   output logic                  wr_req_ready_o,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [LEN_WIDTH-1:0]  wr_len_i,
   input  logic [SID_WIDTH-1:0]  wr_sid_i,

   output logic                  rsp_valid_o,
   output logic                  rsp_port_o,
   output logic                  rsp_allow_o,
   input  logic                  rsp_ready_i,

   output logic [ADDR_WIDTH-1:0] chk_addr_o,
   output logic [LEN_WIDTH-1:0]  chk_len_o,
   output logic [SID_WIDTH-1:0]  chk_sid_o,
   output logic [2:0]            chk_access_o,

   input  logic                  dl_allow_i,
   input  logic                  dl_err_i,
   input  logic [2:0]            dl_err_type_i,
   input  logic [15:0]           dl_err_entry_i,

   input  logic                  err_clear_i,
   output logic                  err_valid_o,
   output logic [2:0]            err_type_o,
   output logic [15:0]           err_entry_o,
   output logic [SID_WIDTH-1:0]  err_sid_o,
   output logic [ADDR_WIDTH-1:0] err_addr_o,
   output logic [2:0]            err_ttype_o
);

   sched_state_e          state_q, state_d;
   logic                  ptr_q, ptr_d;       // 0: read port has priority
   logic                  port_q, port_d;     // port of the request in flight
   logic                  bypass_q, bypass_d; // IOPMP disabled at grant time
   logic                  allow_q, allow_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [SID_WIDTH-1:0]  sid_q, sid_d;
   access_t               acc_q, acc_d;

   logic                  grant_rd, grant_wr;
   logic                  deny;
   logic                  capture;
   err_record_t           rec_in, rec_out;

   // Grant only from IDLE; with both ports valid the pointer decides. Ready
   // is derived from valid, so it never rises without a pending request.
   always_comb begin
      grant_rd = 1'b0;
      grant_wr = 1'b0;
      if (state_q == IDLE) begin
         if (rd_req_valid_i && wr_req_valid_i) begin
            grant_rd = ~ptr_q;
            grant_wr = ptr_q;
         end else begin
            grant_rd = rd_req_valid_i;
            grant_wr = wr_req_valid_i;
         end
      end
   end

   assign rd_req_ready_o = grant_rd;
   assign wr_req_ready_o = grant_wr;

   // allow without err is the only pass; allow=0 with err=0 is a no-hit deny.
   assign deny    = ~bypass_q & ~(dl_allow_i & ~dl_err_i);
   assign capture = (state_q == CHECK) & deny;

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      port_d   = port_q;
      bypass_d = bypass_q;
      allow_d  = allow_q;
      addr_d   = addr_q;
      len_d    = len_q;
      sid_d    = sid_q;
      acc_d    = acc_q;
      unique case (state_q)
         IDLE: begin
            if (grant_rd || grant_wr) begin
               state_d  = CHECK;
               port_d   = grant_wr;
               ptr_d    = ~grant_wr;  // the port not served gets priority next
               bypass_d = ~enable_i;
               addr_d   = grant_wr ? wr_addr_i : rd_addr_i;
               len_d    = grant_wr ? wr_len_i  : rd_len_i;
               sid_d    = grant_wr ? wr_sid_i  : rd_sid_i;
               if (grant_wr) begin
                  acc_d = ACC_WRITE;
               end else if (rd_exec_i) begin
                  acc_d = ACC_EXEC;
               end else begin
                  acc_d = ACC_READ;
               end
            end
         end
         CHECK: begin
            state_d = RESP;
            allow_d = ~deny;
         end
         RESP: begin
            if (rsp_ready_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         ptr_q    <= 1'b0;
         port_q   <= 1'b0;
         bypass_q <= 1'b0;
         allow_q  <= 1'b0;
         addr_q   <= '0;
         len_q    <= '0;
         sid_q    <= '0;
         acc_q    <= ACC_NONE;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         port_q   <= port_d;
         bypass_q <= bypass_d;
         allow_q  <= allow_d;
         addr_q   <= addr_d;
         len_q    <= len_d;
         sid_q    <= sid_d;
         acc_q    <= acc_d;
      end
   end

   // Response outputs are qualified by RESP so they read 0 when not valid.
   assign rsp_valid_o = (state_q == RESP);
   assign rsp_port_o  = rsp_valid_o & port_q;
   assign rsp_allow_o = rsp_valid_o & allow_q;

   assign chk_addr_o   = addr_q;
   assign chk_len_o    = len_q;
   assign chk_sid_o    = sid_q;
   assign chk_access_o = (state_q != IDLE) ? acc_q : ACC_NONE;

   always_comb begin
      rec_in       = '0;
      rec_in.etype = deny_type(dl_err_i, dl_err_type_i);
      rec_in.entry = dl_err_entry_i;
      rec_in.sid   = REC_SID_W'(sid_q);
      rec_in.addr  = REC_ADDR_W'(addr_q);
      rec_in.ttype = acc_q;
   end

   rv_iopmp_err_capture u_err_capture (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .capture_i (capture),
      .clear_i   (err_clear_i),
      .rec_i     (rec_in),
      .valid_o   (err_valid_o),
      .rec_o     (rec_out)
   );

   assign err_type_o  = rec_out.etype;
   assign err_entry_o = rec_out.entry;
   assign err_sid_o   = SID_WIDTH'(rec_out.sid);
   assign err_addr_o  = ADDR_WIDTH'(rec_out.addr);
   assign err_ttype_o = rec_out.ttype;

endmodule

// File: tb/tb_rv_iopmp_chk_sched.sv
`timescale 1ns/1ps
module tb_rv_iopmp_chk_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        rd_valid = 1'b0, rd_ready, rd_exec = 1'b0;
   logic [63:0] rd_addr = '0;
   logic [7:0]  rd_len = '0, rd_sid = '0;
   logic        wr_valid = 1'b0, wr_ready;
   logic [63:0] wr_addr = '0;
   logic [7:0]  wr_len = '0, wr_sid = '0;
   logic        rsp_valid, rsp_port, rsp_allow;
   logic        rsp_ready = 1'b1;
   logic [63:0] chk_addr;
   logic [7:0]  chk_len, chk_sid;
   logic [2:0]  chk_access;
   logic        dl_allow, dl_err;
   logic [2:0]  dl_err_type;
   logic [15:0] dl_err_entry;
   logic        clr_auto = 1'b0, clr_dir = 1'b0;
   logic        err_clear;
   logic        err_valid;
   logic [2:0]  err_type, err_ttype;
   logic [15:0] err_entry;
   logic [7:0]  err_sid;
   logic [63:0] err_addr;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   rv_iopmp_chk_sched dut (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(enable),
      .rd_req_valid_i(rd_valid), .rd_req_ready_o(rd_ready), .rd_addr_i(rd_addr),
      .rd_len_i(rd_len), .rd_sid_i(rd_sid), .rd_exec_i(rd_exec),
      .wr_req_valid_i(wr_valid), .wr_req_ready_o(wr_ready), .wr_addr_i(wr_addr),
      .wr_len_i(wr_len), .wr_sid_i(wr_sid),
      .rsp_valid_o(rsp_valid), .rsp_port_o(rsp_port), .rsp_allow_o(rsp_allow),
      .rsp_ready_i(rsp_ready),
      .chk_addr_o(chk_addr), .chk_len_o(chk_len), .chk_sid_o(chk_sid),
      .chk_access_o(chk_access),
      .dl_allow_i(dl_allow), .dl_err_i(dl_err), .dl_err_type_i(dl_err_type),
      .dl_err_entry_i(dl_err_entry),
      .err_clear_i(err_clear), .err_valid_o(err_valid), .err_type_o(err_type),
      .err_entry_o(err_entry), .err_sid_o(err_sid), .err_addr_o(err_addr),
      .err_ttype_o(err_ttype)
   );

   // Stand-in decision logic: a per-SID verdict table; the reported entry also
   // folds in the address so a wrong chk_addr shows up in the record.
   logic        t_allow [256];
   logic        t_err   [256];
   logic [2:0]  t_type  [256];
   logic [15:0] t_ent   [256];
   assign dl_allow     = t_allow[chk_sid];
   assign dl_err       = t_err[chk_sid];
   assign dl_err_type  = t_type[chk_sid];
   assign dl_err_entry = t_ent[chk_sid] ^ chk_addr[15:0];
   assign err_clear    = clr_auto | clr_dir;

   typedef struct {
      logic [63:0] addr; logic [7:0] len; logic [7:0] sid; logic exec;
   } req_t;
   typedef struct {
      logic port; logic allow; logic deny; logic [2:0] etype; logic [15:0] eent;
      logic [7:0] sid; logic [63:0] addr; logic [2:0] ttype;
   } rsp_t;
   typedef struct {
      logic [63:0] addr; logic [7:0] len; logic [7:0] sid; logic [2:0] acc;
   } chk_t;

   rsp_t rq[$];
   chk_t cq[$];
   int   gq[$];
   int   glog[$];
   int   n_chk = 0, n_fail = 0;
   bit   mptr = 1'b0;             // model round-robin priority (1 = write)
   bit   m_ev = 1'b0;             // model error record
   logic [2:0]  m_et, m_ett;
   logic [15:0] m_ee;
   logic [7:0]  m_es;
   logic [63:0] m_ea;
   bit   rr_rand = 1'b0, clr_rand = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic rsp_t predict(input bit port, input req_t r, input bit en);
      rsp_t e;
      e.port  = port;
      e.sid   = r.sid;
      e.addr  = r.addr;
      e.ttype = port ? 3'b010 : (r.exec ? 3'b100 : 3'b001);
      if (!en) begin
         e.allow = 1'b1;
      end else begin
         e.allow = t_allow[r.sid] && !t_err[r.sid];
      end
      e.deny  = !e.allow;
      e.etype = t_err[r.sid] ? t_type[r.sid] : 3'h5;
      e.eent  = t_ent[r.sid] ^ r.addr[15:0];
      return e;
   endfunction

   function automatic req_t mk(input logic [63:0] a, input logic [7:0] l,
                               input logic [7:0] s, input logic x);
      req_t r;
      r.addr = a; r.len = l; r.sid = s; r.exec = x;
      return r;
   endfunction

   // Called just after a rising edge. Returns just after the edge on which the
   // last request was accepted, i.e. inside that request's CHECK cycle.
   task automatic issue(input bit do_rd, input req_t rr, input bit do_wr, input req_t wr,
                        input bit en, input bit expect_rsp);
      bit   order[$];
      bit   rd_done, wr_done;
      int   k;
      req_t q;
      chk_t c;
      if (do_rd && do_wr) begin
         order.push_back(mptr);
         order.push_back(!mptr);
      end else if (do_rd) begin
         order.push_back(1'b0);
      end else if (do_wr) begin
         order.push_back(1'b1);
      end
      foreach (order[i]) begin
         q = order[i] ? wr : rr;
         if (expect_rsp) begin
            rq.push_back(predict(order[i], q, en));
            c.addr = q.addr; c.len = q.len; c.sid = q.sid;
            c.acc  = order[i] ? 3'b010 : (q.exec ? 3'b100 : 3'b001);
            cq.push_back(c);
         end
         mptr = !order[i];
      end
      enable = en;
      rd_addr = rr.addr; rd_len = rr.len; rd_sid = rr.sid; rd_exec = rr.exec;
      wr_addr = wr.addr; wr_len = wr.len; wr_sid = wr.sid;
      rd_valid = do_rd; wr_valid = do_wr;
      rd_done = !do_rd; wr_done = !do_wr;
      k = 0;
      while (!(rd_done && wr_done) && k < 200) begin
         @(negedge clk);
         if (rd_ready) rd_done = 1'b1;
         if (wr_ready) wr_done = 1'b1;
         @(posedge clk); #1;
         if (rd_done) rd_valid = 1'b0;
         if (wr_done) wr_valid = 1'b0;
         k++;
      end
      chk("grant_done", 64'(rd_done && wr_done), 64'd1);
      rd_valid = 1'b0; wr_valid = 1'b0;
   endtask

   task automatic drain();
      int k = 0;
      while (rq.size() != 0 && k < 400) begin
         @(posedge clk);
         k++;
      end
      chk("drain_rsp_queue", 64'(rq.size()), 64'd0);
      @(posedge clk); #1;
   endtask

   task automatic clear_rec();
      clr_dir = 1'b1;
      m_ev = 1'b0;
      @(posedge clk); #1;
      clr_dir = 1'b0;
      chk("err_valid_after_clear", 64'(err_valid), 64'd0);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_rd_ready"},  64'(rd_ready), 64'd0);
      chk({tag, "_wr_ready"},  64'(wr_ready), 64'd0);
      chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
      chk({tag, "_rsp_port"},  64'(rsp_port), 64'd0);
      chk({tag, "_rsp_allow"}, 64'(rsp_allow), 64'd0);
      chk({tag, "_chk_addr"},  chk_addr, 64'd0);
      chk({tag, "_chk_len"},   64'(chk_len), 64'd0);
      chk({tag, "_chk_sid"},   64'(chk_sid), 64'd0);
      chk({tag, "_chk_access"}, 64'(chk_access), 64'd0);
      chk({tag, "_err_valid"}, 64'(err_valid), 64'd0);
      chk({tag, "_err_type"},  64'(err_type), 64'd0);
      chk({tag, "_err_entry"}, 64'(err_entry), 64'd0);
      chk({tag, "_err_sid"},   64'(err_sid), 64'd0);
      chk({tag, "_err_addr"},  err_addr, 64'd0);
      chk({tag, "_err_ttype"}, 64'(err_ttype), 64'd0);
   endtask

   // Response consumer
   initial begin
      forever begin
         @(posedge clk); #1;
         rsp_ready = rr_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
   end

   // Monitor / scoreboard
   initial begin
      bit   prev_grant, prev_rv, do_clr;
      rsp_t e;
      chk_t c;
      prev_grant = 1'b0; prev_rv = 1'b0;
      forever begin
         @(negedge clk);
         do_clr = 1'b0;
         if (!rst_n) begin
            prev_grant = 1'b0; prev_rv = 1'b0;
            continue;
         end
         chk("ready_without_valid", 64'((rd_ready && !rd_valid) || (wr_ready && !wr_valid)), 64'd0);
         chk("double_grant", 64'(rd_ready && wr_ready), 64'd0);
         if (prev_grant) begin
            if (cq.size() == 0) begin
               chk("unexpected_check", 64'd1, 64'd0);
            end else begin
               c = cq.pop_front();
               chk("chk_addr", chk_addr, c.addr);
               chk("chk_len", 64'(chk_len), 64'(c.len));
               chk("chk_sid", 64'(chk_sid), 64'(c.sid));
               chk("chk_access", 64'(chk_access), 64'(c.acc));
            end
         end
         if (rsp_valid && !prev_rv) begin
            if (gq.size() == 0) chk("rsp_without_grant", 64'd1, 64'd0);
            else chk("rsp_latency", 64'(cyc - gq.pop_front()), 64'd2);
         end
         if (rsp_valid && rsp_ready) begin
            if (rq.size() == 0) begin
               chk("unexpected_rsp", 64'd1, 64'd0);
            end else begin
               e = rq.pop_front();
               chk("rsp_port", 64'(rsp_port), 64'(e.port));
               chk("rsp_allow", 64'(rsp_allow), 64'(e.allow));
               if (e.deny && !m_ev) begin
                  m_ev = 1'b1; m_et = e.etype; m_ee = e.eent;
                  m_es = e.sid; m_ea = e.addr; m_ett = e.ttype;
               end
               chk("err_valid", 64'(err_valid), 64'(m_ev));
               if (m_ev) begin
                  chk("err_type", 64'(err_type), 64'(m_et));
                  chk("err_entry", 64'(err_entry), 64'(m_ee));
                  chk("err_sid", 64'(err_sid), 64'(m_es));
                  chk("err_addr", err_addr, m_ea);
                  chk("err_ttype", 64'(err_ttype), 64'(m_ett));
               end
               do_clr = clr_rand && m_ev && ($urandom_range(0, 3) == 0);
            end
         end
         prev_grant = rd_ready || wr_ready;
         if (prev_grant) begin
            gq.push_back(cyc);
            glog.push_back(cyc);
         end
         prev_rv = rsp_valid;
         if (do_clr) begin
            clr_auto = 1'b1;
            m_ev = 1'b0;
            @(posedge clk); #1;
            clr_auto = 1'b0;
         end
      end
   end

   // Stimulus
   initial begin
      req_t a, b, z;
      int   sel, n;
      for (int i = 0; i < 256; i++) begin
         t_allow[i] = 1'b1; t_err[i] = 1'b0; t_type[i] = 3'h0; t_ent[i] = 16'h0;
      end
      z = mk(64'h0, 8'h0, 8'h0, 1'b0);

      repeat (3) @(posedge clk); #1;
      check_zero("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Both ports valid right after reset: read first, write three cycles later.
      issue(1'b1, mk(64'h2000, 8'h3, 8'h5, 1'b0), 1'b1, mk(64'h3000, 8'h7, 8'h6, 1'b0), 1'b1, 1'b1);
      chk("both_gap_cycles", 64'(glog[glog.size()-1] - glog[glog.size()-2]), 64'd3);
      drain();

      // Single read, allowed.
      issue(1'b1, mk(64'h1000, 8'h0, 8'h1, 1'b0), 1'b0, z, 1'b1, 1'b1);
      drain();

      // Write denied with an explicit error.
      t_allow[8'h22] = 1'b0; t_err[8'h22] = 1'b1; t_type[8'h22] = 3'h2; t_ent[8'h22] = 16'h4;
      issue(1'b0, z, 1'b1, mk(64'h8000_0000, 8'h1, 8'h22, 1'b0), 1'b1, 1'b1);
      drain();
      chk("wr_deny_err_valid", 64'(err_valid), 64'd1);
      chk("wr_deny_err_type", 64'(err_type), 64'd2);
      chk("wr_deny_err_entry", 64'(err_entry), 64'd4);
      chk("wr_deny_err_ttype", 64'(err_ttype), 64'b010);

      // Two denials back-to-back: the first one is kept.
      clear_rec();
      t_allow[8'h33] = 1'b0; t_err[8'h33] = 1'b0; t_ent[8'h33] = 16'h7;
      issue(1'b1, mk(64'h0010_0000, 8'h2, 8'h33, 1'b0), 1'b0, z, 1'b1, 1'b1);
      issue(1'b0, z, 1'b1, mk(64'h0001_0000, 8'h2, 8'h22, 1'b0), 1'b1, 1'b1);
      drain();
      chk("first_err_sid", 64'(err_sid), 64'h33);
      chk("first_err_type_nohit", 64'(err_type), 64'h5);
      chk("first_err_ttype", 64'(err_ttype), 64'b001);
      // Third denial with a clear landing in its check cycle: capture wins.
      issue(1'b1, mk(64'h3000_0000, 8'h0, 8'h22, 1'b1), 1'b0, z, 1'b1, 1'b1);
      clr_dir = 1'b1;
      m_ev = 1'b0;
      @(posedge clk); #1;
      clr_dir = 1'b0;
      drain();
      chk("third_err_valid", 64'(err_valid), 64'd1);
      chk("third_err_sid", 64'(err_sid), 64'h22);
      chk("third_err_ttype", 64'(err_ttype), 64'b100);

      // Disabled IOPMP: bypass, no error recorded.
      clear_rec();
      t_allow[8'h44] = 1'b0; t_err[8'h44] = 1'b0;
      issue(1'b1, mk(64'h4000, 8'h1, 8'h44, 1'b0), 1'b0, z, 1'b0, 1'b1);
      drain();
      chk("bypass_err_valid", 64'(err_valid), 64'd0);

      // Randomized traffic.
      for (int i = 0; i < 256; i++) begin
         t_allow[i] = ($urandom_range(0, 3) != 0);
         t_err[i]   = ($urandom_range(0, 4) == 0);
         case ($urandom_range(0, 3))
            0: t_type[i] = 3'h1;
            1: t_type[i] = 3'h2;
            2: t_type[i] = 3'h3;
            default: t_type[i] = 3'h6;
         endcase
         t_ent[i] = 16'($urandom);
      end
      rr_rand = 1'b1; clr_rand = 1'b1;
      for (int i = 0; i < 150; i++) begin
         sel = $urandom_range(0, 2);
         a = mk({$urandom, $urandom}, 8'($urandom), 8'($urandom), 1'($urandom));
         b = mk({$urandom, $urandom}, 8'($urandom), 8'($urandom), 1'b0);
         issue(sel != 1, a, sel != 0, b, $urandom_range(0, 4) != 0, 1'b1);
         n = $urandom_range(0, 2);
         repeat (n) begin @(posedge clk); #1; end
      end
      drain();
      rr_rand = 1'b0; clr_rand = 1'b0;
      repeat (3) begin @(posedge clk); #1; end

      // Reset during CHECK: leave the pointer at write first, then abort.
      t_allow[8'h01] = 1'b1; t_err[8'h01] = 1'b0;
      issue(1'b1, mk(64'h1000, 8'h0, 8'h1, 1'b0), 1'b0, z, 1'b1, 1'b1);
      drain();
      issue(1'b1, mk(64'h5000, 8'h4, 8'h1, 1'b0), 1'b0, z, 1'b1, 1'b0);
      rst_n = 1'b0;
      #1;
      check_zero("midrst");
      repeat (3) begin
         @(negedge clk);
         chk("midrst_no_rsp", 64'(rsp_valid), 64'd0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      mptr = 1'b0; m_ev = 1'b0;
      gq.delete(); cq.delete();
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
         chk("post_rst_chk_access", 64'(chk_access), 64'd0);
         chk("post_rst_err_valid", 64'(err_valid), 64'd0);
      end
      @(posedge clk); #1;
      issue(1'b1, mk(64'h6000, 8'h1, 8'h1, 1'b0), 1'b1, mk(64'h7000, 8'h2, 8'h1, 1'b0), 1'b1, 1'b1);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

endmodule
